ika9958_vtgen: RTL

Parametrised video timing generator, the successor to the fixed screen-timing block.
- Produces dot/line counters, sync, blanking, field and line-match strobes for the VDP pipeline.
- Supports NTSC/PAL, 192/212 active lines and interlace, selected at runtime.
- Advances on a dot-clock enable derived from the master clock, inside the same IKA9958 clock domain.

---
 rtl/ika9958_vtgen_pkg.sv | 38 +++
 rtl/ika9958_vtgen_if.sv | 44 ++++
 rtl/ika9958_vtgen_win.sv | 27 ++
 rtl/ika9958_vtgen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ika9958_vtgen_pkg.sv
// Shared types and helpers for the IKA9958 video timing generator.
package ika9958_vtgen_pkg;

    localparam int HCNT_W_DEF       = 9;
    localparam int VCNT_W_DEF       = 9;
    localparam int V_TOTAL_NTSC_DEF = 262;
    localparam int V_TOTAL_PAL_DEF  = 313;
    localparam int VA_192           = 192;
    localparam int VA_212           = 212;

    typedef logic [HCNT_W_DEF-1:0] hcnt_t;
    typedef logic [VCNT_W_DEF-1:0] vcnt_t;

    typedef struct packed {
        logic pal;
        logic ln;
        logic il;
    } mode_t;

    // Odd interlaced fields carry one extra line.
    function automatic int vtotal(input mode_t m, input logic field,
                                  input int vt_ntsc = V_TOTAL_NTSC_DEF,
                                  input int vt_pal  = V_TOTAL_PAL_DEF);
        return (m.pal ? vt_pal : vt_ntsc) + int'(m.il & field);
    endfunction

    function automatic int wrap_add(input int base, input logic signed [3:0] d,
                                    input int total);
        int s;
        s = base + int'(d);
        if (s < 0)
            s = s + total;
        else if (s >= total)
            s = s - total;
        return s;
    endfunction

endpackage

// File: rtl/ika9958_vtgen_if.sv
// Mode inputs and timing outputs of the video timing generator.
// i_ADJ exists only when IKA9958_VTGEN_DISPADJ_EN is defined.
interface ika9958_vtgen_if
    import ika9958_vtgen_pkg::*;
#(
    parameter int HCNT_W = HCNT_W_DEF,
    parameter int VCNT_W = VCNT_W_DEF
);
    logic              i_DOTCEN_n;
    logic              i_PAL;
    logic              i_LN;
    logic              i_IL;
    logic [VCNT_W-1:0] i_LMATCH;
`ifdef IKA9958_VTGEN_DISPADJ_EN
    logic [7:0]        i_ADJ;
`endif
    logic [HCNT_W-1:0] o_HCNT;
    logic [VCNT_W-1:0] o_VCNT;
    logic              o_HSYNC_n;
    logic              o_VSYNC_n;
    logic              o_HBLANK;
    logic              o_VBLANK;
    logic              o_FIELD;
    logic              o_LINE_STB;
    logic              o_FRAME_STB;

    modport master (
        output i_DOTCEN_n, i_PAL, i_LN, i_IL, i_LMATCH,
`ifdef IKA9958_VTGEN_DISPADJ_EN
        output i_ADJ,
`endif
        input  o_HCNT, o_VCNT, o_HSYNC_n, o_VSYNC_n, o_HBLANK, o_VBLANK,
        input  o_FIELD, o_LINE_STB, o_FRAME_STB
    );

    modport slave (
        input  i_DOTCEN_n, i_PAL, i_LN, i_IL, i_LMATCH,
`ifdef IKA9958_VTGEN_DISPADJ_EN
        input  i_ADJ,
`endif
        output o_HCNT, o_VCNT, o_HSYNC_n, o_VSYNC_n, o_HBLANK, o_VBLANK,
        output o_FIELD, o_LINE_STB, o_FRAME_STB
    );
endinterface

// File: rtl/ika9958_vtgen_win.sv
// Registered modular window: active while (cnt - start) mod total < len.
module ika9958_vtgen_win #(
    parameter int W = 9
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         en,
    input  logic [W-1:0] start,
    input  logic [W-1:0] len,
    input  logic [W:0]   total,
    input  logic [W-1:0] cnt,
    output logic         active
);
    logic [W:0] c, s, ofs;

    assign c   = {1'b0, cnt};
    assign s   = {1'b0, start};
    // total is one bit wider so a total of exactly 2^W still fits
    assign ofs = (c >= s) ? (c - s) : (c + total - s);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            active <= 1'b0;
        else if (en)
            active <= (ofs < {1'b0, len});
    end
endmodule

// File: rtl/ika9958_vtgen.sv
// IKA9958 video timing generator: dot/line counters, sync, blank, field, strobes.
// Optional sync position adjust via macro IKA9958_VTGEN_DISPADJ_EN.
module ika9958_vtgen
    import ika9958_vtgen_pkg::*;
#(
    parameter int HCNT_W       = HCNT_W_DEF,
    parameter int VCNT_W       = VCNT_W_DEF,
    parameter int H_TOTAL      = 342,
    parameter int H_ACTIVE     = 256,
    parameter int HSYNC_START  = 282,
    parameter int HSYNC_LEN    = 26,
    parameter int V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
    parameter int V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
    parameter int VSYNC_LEN    = 3
) (
    input  logic           i_EMUCLK,
    input  logic           i_HRST_n,
    ika9958_vtgen_if.slave vt
);
    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W:0]   H_TOT  = (HCNT_W+1)'(H_TOTAL);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_LEN = HCNT_W'(HSYNC_LEN);
    localparam logic [VCNT_W-1:0] VS_LEN = VCNT_W'(VSYNC_LEN);

    if (H_TOTAL > (1 << HCNT_W)) begin : g_hchk
        $error("H_TOTAL does not fit in HCNT_W bits");
    end
    if (V_TOTAL_PAL + 1 > (1 << VCNT_W)) begin : g_vchk
        $error("V_TOTAL_PAL+1 does not fit in VCNT_W bits");
    end

    logic              en, eol, eof;
    logic              primed_q, field_q, field_nxt;
    logic [HCNT_W-1:0] hcnt_q, h_nxt, hs_start;
    logic [VCNT_W-1:0] vcnt_q, v_nxt, vt_cur, vt_nxt, va_nxt, vs_start;
    mode_t             mode_q, mode_in, mode_nxt;
    logic              hblank_q, vblank_q, frame_stb_q, line_stb_q;
    logic              hs_act, vs_act;

    assign en      = ~vt.i_DOTCEN_n;
    assign mode_in = {vt.i_PAL, vt.i_LN, vt.i_IL};
    assign vt_cur  = VCNT_W'(vtotal(mode_q, field_q, V_TOTAL_NTSC, V_TOTAL_PAL));
    assign eol     = primed_q && (hcnt_q == H_LAST);
    assign eof     = eol && (vcnt_q == vt_cur - VCNT_W'(1));

    // The first enabled cycle after reset holds the counters at 0,0 so the
    // frame strobe for that position is emitted aligned with the counters.
    always_comb begin
        h_nxt     = hcnt_q;
        v_nxt     = vcnt_q;
        mode_nxt  = mode_q;
        field_nxt = field_q;
        if (primed_q) begin
            if (eol) begin
                h_nxt = '0;
                v_nxt = eof ? '0 : vcnt_q + VCNT_W'(1);
            end else begin
                h_nxt = hcnt_q + HCNT_W'(1);
            end
            if (eof) begin
                mode_nxt  = mode_in;
                field_nxt = mode_in.il ? ~field_q : 1'b0;
            end
        end
    end

    assign vt_nxt = VCNT_W'(vtotal(mode_nxt, field_nxt, V_TOTAL_NTSC, V_TOTAL_PAL));
    assign va_nxt = mode_nxt.ln ? VCNT_W'(VA_212) : VCNT_W'(VA_192);

`ifdef IKA9958_VTGEN_DISPADJ_EN
    logic [7:0] adj_q, adj_nxt;

    assign adj_nxt  = eof ? vt.i_ADJ : adj_q;
    assign hs_start = HCNT_W'(wrap_add(HSYNC_START, adj_nxt[3:0], H_TOTAL));
    assign vs_start = VCNT_W'(wrap_add(int'(vt_nxt) - VSYNC_LEN, adj_nxt[7:4],
                                       int'(vt_nxt)));

    always_ff @(posedge i_EMUCLK or negedge i_HRST_n) begin
        if (!i_HRST_n)
            adj_q <= '0;
        else if (en)
            adj_q <= adj_nxt;
    end
`else
    assign hs_start = HCNT_W'(HSYNC_START);
    assign vs_start = vt_nxt - VS_LEN;
`endif

    // Decodes look at the next counter values so they line up with o_HCNT/o_VCNT.
    always_ff @(posedge i_EMUCLK or negedge i_HRST_n) begin
        if (!i_HRST_n) begin
            primed_q    <= 1'b0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            mode_q      <= '0;
            field_q     <= 1'b0;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            frame_stb_q <= 1'b0;
            line_stb_q  <= 1'b0;
        end else if (en) begin
            primed_q    <= 1'b1;
            hcnt_q      <= h_nxt;
            vcnt_q      <= v_nxt;
            mode_q      <= mode_nxt;
            field_q     <= field_nxt;
            hblank_q    <= (h_nxt >= H_ACT);
            vblank_q    <= (v_nxt >= va_nxt);
            frame_stb_q <= (h_nxt == '0) && (v_nxt == '0);
            line_stb_q  <= (h_nxt == '0) && (v_nxt == vt.i_LMATCH);
        end
    end

    ika9958_vtgen_win #(.W(HCNT_W)) u_hsync (
        .gclk   (i_EMUCLK),
        .grst_n (i_HRST_n),
        .en     (en),
        .start  (hs_start),
        .len    (HS_LEN),
        .total  (H_TOT),
        .cnt    (h_nxt),
        .active (hs_act)
    );

    ika9958_vtgen_win #(.W(VCNT_W)) u_vsync (
        .gclk   (i_EMUCLK),
        .grst_n (i_HRST_n),
        .en     (en),
        .start  (vs_start),
        .len    (VS_LEN),
        .total  ({1'b0, vt_nxt}),
        .cnt    (v_nxt),
        .active (vs_act)
    );

    assign vt.o_HCNT      = hcnt_q;
    assign vt.o_VCNT      = vcnt_q;
    assign vt.o_HSYNC_n   = ~hs_act;
    assign vt.o_VSYNC_n   = ~vs_act;
    assign vt.o_HBLANK    = hblank_q;
    assign vt.o_VBLANK    = vblank_q;
    assign vt.o_FIELD     = field_q;
    assign vt.o_LINE_STB  = line_stb_q;
    assign vt.o_FRAME_STB = frame_stb_q;
endmodule
